order_matcher: RTL
==================

Name: order_matcher

Overview:
- Single-level limit-order matching stage that sits directly upstream of the trade counter.
- Accepts buy/sell orders over a valid/ready handshake and holds one resting bid level and one resting ask level.
- On a crossing order, produces a one-cycle match_signal pulse with the trade price and quantity; the pulse feeds the counter's match_signal input.
- Honours the counter's halt_signal by refusing new orders.

Parameters:
PRICE_W, 8, price field width (unsigned)
QTY_W, 8, quantity field width (unsigned)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
order_valid  input  1  order present on order_* fields
order_ready  output  1  block can accept an order this cycle
order_side  input  1  0 = buy, 1 = sell
order_price  input  PRICE_W  limit price
order_qty  input  QTY_W  order quantity
halt  input  1  from counter halt_signal; blocks acceptance
match_signal  output  1  one-cycle pulse per trade
trade_price  output  PRICE_W  price of last trade; held between trades
trade_qty  output  QTY_W  quantity of last trade; held between trades
reject  output  1  one-cycle pulse, order accepted but discarded
bid_valid  output  1  resting bid present
bid_price  output  PRICE_W  resting bid price
bid_qty  output  QTY_W  resting bid quantity
ask_valid  output  1  resting ask present
ask_price  output  PRICE_W  resting ask price
ask_qty  output  QTY_W  resting ask quantity

Behaviour:
- Reset (async): state=IDLE; every registered output cleared to 0 (match_signal, reject, trade_*, bid_*, ask_*).
- order_ready = (state==IDLE) && !halt, combinational. Acceptance happens in cycle N when order_valid && order_ready.
- FSM states:
  - IDLE: accepts orders.
  - IDLE -> MATCH: on a crossing acceptance.
  - MATCH -> COOL: unconditional.
  - COOL -> IDLE: unconditional.
  - Non-crossing acceptances stay in IDLE, so they sustain one order per cycle.
- match_signal=1 only in MATCH, i.e. cycle N+1 after a crossing acceptance. It is low in COOL, which guarantees a low cycle between pulses so a downstream edge detector sees every trade. Maximum trade rate is one per 3 cycles.
- Book invariant: if bid_valid && ask_valid, then bid_price < ask_price.
- Buy order, effects visible at N+1:
  - qty==0: reject; book unchanged.
  - Cross (ask_valid && price >= ask_price):
    - t = min(order_qty, ask_qty); trade_price = ask_price (resting price wins); trade_qty = t.
    - ask_qty -= t; ask_valid cleared if the result is 0 (ask_price/ask_qty then read 0).
    - Residual r = order_qty - t. If r > 0, the bid is replaced with (order_price, r), which is a strict improvement by the invariant. If r == 0, the bid is unchanged.
  - No cross, !bid_valid or price > bid_price: bid := (price, qty).
  - No cross, price == bid_price: bid_qty = saturating add, clamped to 2^QTY_W-1.
  - No cross, price < bid_price: reject; book unchanged.
- Sell order: mirror of buy.
  - Cross on bid_valid && price <= bid_price; trade at bid_price.
  - Improvement means price < ask_price; equal price aggregates; higher price is rejected.
- Exclusivity: reject and match_signal never assert in the same cycle; reject is a one-cycle pulse at N+1.
- halt:
  - Asserting halt during MATCH or COOL does not abort the sequence; the book and trade outputs complete normally.
  - Once halted, order_ready stays 0. The book is frozen but remains readable.
- Reset asserted mid-MATCH: match_signal drops immediately (async clear); the book is empty afterwards.
- No arithmetic wraps. Price comparisons are unsigned. Quantity subtraction cannot underflow because t <= both operands.

Test Plan:
- Reset, then: buy(price=50, qty=10) accepted -> next cycle bid_valid=1, bid_price=50, bid_qty=10, match_signal=0, reject=0, order_ready=1.
- With bid 50/10: sell(48, 4) -> N+1: match_signal=1, trade_price=50, trade_qty=4, bid_qty=6; order_ready=0 for N+1 and N+2; match_signal=0 at N+2.
- With ask 60/5: buy(65, 12) -> trade_price=60, trade_qty=5, ask_valid=0, bid becomes 65/7. Back-to-back valid orders: the second is accepted only at N+3.
- Aggregation/saturation/reject: bid 50/250 plus buy(50, 10) -> bid_qty=255. Buy(40, 3) -> reject=1, book unchanged. Sell(70, 0) -> reject=1.
- halt: assert halt in the MATCH cycle of a cross -> trade completes (match_signal one cycle); order_ready stays 0 while halt=1 with order_valid held high; book unchanged.
- Assert reset during MATCH -> match_signal, bid_valid, ask_valid and trade_qty read 0 before the next clock edge; after release, order_ready=1 with halt=0.

Source files
------------

// File: rtl/order_matcher.sv
// Single-level limit-order matcher: one resting bid, one resting ask.
// A crossing order yields a one-cycle match_signal pulse, followed by a cooldown cycle.
module order_matcher #(
    parameter int PRICE_W = 8,
    parameter int QTY_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               order_valid,
    output logic               order_ready,
    input  logic               order_side,
    input  logic [PRICE_W-1:0] order_price,
    input  logic [QTY_W-1:0]   order_qty,
    input  logic               halt,
    output logic               match_signal,
    output logic [PRICE_W-1:0] trade_price,
    output logic [QTY_W-1:0]   trade_qty,
    output logic               reject,
    output logic               bid_valid,
    output logic [PRICE_W-1:0] bid_price,
    output logic [QTY_W-1:0]   bid_qty,
    output logic               ask_valid,
    output logic [PRICE_W-1:0] ask_price,
    output logic [QTY_W-1:0]   ask_qty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t state;

    logic               accept;
    logic               buy_cross;
    logic               sell_cross;
    logic [QTY_W-1:0]   opp_qty;
    logic [QTY_W-1:0]   own_qty;
    logic [QTY_W-1:0]   t_qty;
    logic [QTY_W-1:0]   r_qty;
    logic [QTY_W-1:0]   left_qty;
    logic [QTY_W:0]     agg_sum;
    logic [QTY_W-1:0]   agg_qty;

    logic               n_match;
    logic               n_reject;
    logic [PRICE_W-1:0] n_trade_price;
    logic [QTY_W-1:0]   n_trade_qty;
    logic               n_bid_valid;
    logic [PRICE_W-1:0] n_bid_price;
    logic [QTY_W-1:0]   n_bid_qty;
    logic               n_ask_valid;
    logic [PRICE_W-1:0] n_ask_price;
    logic [QTY_W-1:0]   n_ask_qty;

    assign order_ready = (state == IDLE) && !halt;
    assign accept      = order_valid && order_ready;

    assign buy_cross  = ask_valid && (order_price >= ask_price);
    assign sell_cross = bid_valid && (order_price <= bid_price);

    // opp_qty is the resting side being hit, own_qty the side being joined
    assign opp_qty  = order_side ? bid_qty : ask_qty;
    assign own_qty  = order_side ? ask_qty : bid_qty;
    assign t_qty    = (order_qty < opp_qty) ? order_qty : opp_qty;
    assign r_qty    = order_qty - t_qty;
    assign left_qty = opp_qty - t_qty;

    assign agg_sum = {1'b0, own_qty} + {1'b0, order_qty};
    assign agg_qty = agg_sum[QTY_W] ? {QTY_W{1'b1}} : agg_sum[QTY_W-1:0];

    always_comb begin
        n_match       = 1'b0;
        n_reject      = 1'b0;
        n_trade_price = trade_price;
        n_trade_qty   = trade_qty;
        n_bid_valid   = bid_valid;
        n_bid_price   = bid_price;
        n_bid_qty     = bid_qty;
        n_ask_valid   = ask_valid;
        n_ask_price   = ask_price;
        n_ask_qty     = ask_qty;
        if (accept) begin
            priority case (1'b1)
                order_qty == '0: n_reject = 1'b1;
                !order_side && buy_cross: begin
                    n_match       = 1'b1;
                    n_trade_price = ask_price;
                    n_trade_qty   = t_qty;
                    n_ask_qty     = left_qty;
                    if (left_qty == '0) begin
                        n_ask_valid = 1'b0;
                        n_ask_price = '0;
                    end
                    if (r_qty != '0) begin
                        n_bid_valid = 1'b1;
                        n_bid_price = order_price;
                        n_bid_qty   = r_qty;
                    end
                end
                order_side && sell_cross: begin
                    n_match       = 1'b1;
                    n_trade_price = bid_price;
                    n_trade_qty   = t_qty;
                    n_bid_qty     = left_qty;
                    if (left_qty == '0) begin
                        n_bid_valid = 1'b0;
                        n_bid_price = '0;
                    end
                    if (r_qty != '0) begin
                        n_ask_valid = 1'b1;
                        n_ask_price = order_price;
                        n_ask_qty   = r_qty;
                    end
                end
                !order_side && (!bid_valid || order_price > bid_price): begin
                    n_bid_valid = 1'b1;
                    n_bid_price = order_price;
                    n_bid_qty   = order_qty;
                end
                !order_side && (order_price == bid_price): n_bid_qty = agg_qty;
                order_side && (!ask_valid || order_price < ask_price): begin
                    n_ask_valid = 1'b1;
                    n_ask_price = order_price;
                    n_ask_qty   = order_qty;
                end
                order_side && (order_price == ask_price): n_ask_qty = agg_qty;
                default: n_reject = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            match_signal <= 1'b0;
            reject       <= 1'b0;
            trade_price  <= '0;
            trade_qty    <= '0;
            bid_valid    <= 1'b0;
            bid_price    <= '0;
            bid_qty      <= '0;
            ask_valid    <= 1'b0;
            ask_price    <= '0;
            ask_qty      <= '0;
        end else begin
            unique case (state)
                IDLE:    state <= n_match ? MATCH : IDLE;
                MATCH:   state <= COOL;
                COOL:    state <= IDLE;
                default: state <= IDLE;
            endcase
            match_signal <= n_match;
            reject       <= n_reject;
            trade_price  <= n_trade_price;
            trade_qty    <= n_trade_qty;
            bid_valid    <= n_bid_valid;
            bid_price    <= n_bid_price;
            bid_qty      <= n_bid_qty;
            ask_valid    <= n_ask_valid;
            ask_price    <= n_ask_price;
            ask_qty      <= n_ask_qty;
        end
    end

endmodule
